// File: rtl/wallace_pkg.sv
// Shared widths and the operand record for the wallace multiplier and its
// multiply-accumulate consumer.
package wallace_pkg;

  localparam int OP_W      = 32;
  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 72;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            last;
  } operand_t;

endpackage

// File: rtl/wallace.sv
// Combinational 32x32 unsigned multiplier: partial products reduced with
// 3:2 carry-save compressors, then a single carry-propagate add.
module wallace
  import wallace_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] c
);

  logic [PROD_W-1:0] pp [OP_W];
  logic [PROD_W-1:0] sumV;
  logic [PROD_W-1:0] carryV;
  logic [PROD_W-1:0] tmpV;

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
    end
    sumV   = pp[0];
    carryV = '0;
    tmpV   = '0;
    // Carries beyond bit 63 are dropped: the true product always fits.
    for (int i = 1; i < OP_W; i++) begin
      tmpV   = sumV ^ carryV ^ pp[i];
      carryV = ((sumV & carryV) | (sumV & pp[i]) | (carryV & pp[i])) << 1;
      sumV   = tmpV;
    end
  end

  assign c = sumV + carryV;

endmodule

// File: rtl/wallace_mac.sv
// Three-stage unsigned multiply-accumulate: operand register, product
// register, then a group accumulator feeding a held result register.
module wallace_mac
  import wallace_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  operand_t          op_d, s1_q;
  logic              s1_valid_q, s2_valid_q, s2_last_q;
  logic [PROD_W-1:0] prod, s2_prod_q;
  logic [ACC_W-1:0]  acc_q, out_acc_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, out_count_q;
  logic              ovf_q, ovf_d, out_ovf_q, out_valid_q;
  logic [ACC_W:0]    sum_d;
  logic              stall, load_s3;

  assign op_d     = '{a: in_a, b: in_b, last: in_last};
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign load_s3  = s2_valid_q && !stall;

  wallace u_wallace (
    .a (s1_q.a),
    .b (s1_q.b),
    .c (prod)
  );

  assign sum_d = {1'b0, acc_q} + (ACC_W+1)'(s2_prod_q);
  assign ovf_d = ovf_q | sum_d[ACC_W];
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= op_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_q.last;
      s2_prod_q  <= prod;
    end
  end

  // The running group state clears on its last term so the next term
  // begins a fresh group with no extra cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (load_s3) begin
      if (s2_last_q) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= sum_d[ACC_W-1:0];
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (load_s3 && s2_last_q) begin
      out_valid_q <= 1'b1;
      out_acc_q   <= sum_d[ACC_W-1:0];
      out_count_q <= cnt_d;
      out_ovf_q   <= ovf_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_acc      = out_acc_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_wallace_mac.sv
// Bench for wallace_mac: a 72-bit and a 64-bit/4-bit-count instance share
// stimulus; a group-level scoreboard plus constant vectors check both.
module tb_wallace_mac;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [71:0] out_acc0;
  logic [63:0] out_acc1;
  logic [15:0] out_count0;
  logic [3:0]  out_count1;
  logic        out_ovf0, out_ovf1;

  typedef struct {
    logic [127:0] acc;
    int           cnt;
    bit           ovf;
  } res_t;

  typedef struct {
    logic [31:0]  a;
    logic [31:0]  b;
    logic [127:0] expProd;
  } vec_t;

  int           nCompared = 0;
  int           nMismatch = 0;
  bit           randReady = 0;
  res_t         expQ0[$], expQ1[$];
  logic [128:0] mAcc [2];
  int           mCnt [2];
  bit           mOvf [2];
  int           accW [2] = '{72, 64};
  int           cntW [2] = '{16, 4};
  vec_t         vecs [7];

  always #5 clock = ~clock;

  wallace_mac #(.ACC_W(72), .CNT_W(16)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_acc(out_acc0), .out_count(out_count0),
    .out_overflow(out_ovf0)
  );

  wallace_mac #(.ACC_W(64), .CNT_W(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_acc(out_acc1), .out_count(out_count1),
    .out_overflow(out_ovf1)
  );

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] acc, input int cnt,
                             input bit ovf, input bit haveExp, input res_t exp);
    if (!haveExp) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL %s unexpected result: got acc 0x%0h count %0d, expected none", tag, acc, cnt);
    end else begin
      checkVal({tag, " acc"}, acc, exp.acc);
      checkVal({tag, " count"}, 128'(cnt), 128'(exp.cnt));
      checkVal({tag, " ovf"}, 128'(ovf), 128'(exp.ovf));
    end
  endtask

  // Group-level reference: accumulate each accepted term with plain arithmetic.
  task automatic modelAccept(input logic [31:0] a, input logic [31:0] b, input bit last);
    logic [63:0]  p;
    logic [128:0] s, mask;
    res_t         r;
    p = 64'(a) * 64'(b);
    for (int i = 0; i < 2; i++) begin
      mask    = (129'(1) << accW[i]) - 129'(1);
      s       = mAcc[i] + 129'(p);
      mOvf[i] = mOvf[i] | ((s >> accW[i]) != 0);
      mAcc[i] = s & mask;
      mCnt[i] = (mCnt[i] + 1 > (1 << cntW[i]) - 1) ? (1 << cntW[i]) - 1 : mCnt[i] + 1;
      if (last) begin
        r.acc = mAcc[i][127:0];
        r.cnt = mCnt[i];
        r.ovf = mOvf[i];
        if (i == 0) expQ0.push_back(r);
        else expQ1.push_back(r);
        mAcc[i] = '0;
        mCnt[i] = 0;
        mOvf[i] = 0;
      end
    end
  endtask

  task automatic modelClear();
    expQ0.delete();
    expQ1.delete();
    for (int i = 0; i < 2; i++) begin
      mAcc[i] = '0;
      mCnt[i] = 0;
      mOvf[i] = 0;
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      modelClear();
    end else begin
      if (out_valid0) begin
        if (expQ0.size() == 0) checkOutput("dut72", 128'(out_acc0), int'(out_count0), out_ovf0, 0, '{default: 0});
        else begin
          checkOutput("dut72", 128'(out_acc0), int'(out_count0), out_ovf0, 1, expQ0[0]);
          if (out_ready) void'(expQ0.pop_front());
        end
      end
      if (out_valid1) begin
        if (expQ1.size() == 0) checkOutput("dut64", 128'(out_acc1), int'(out_count1), out_ovf1, 0, '{default: 0});
        else begin
          checkOutput("dut64", 128'(out_acc1), int'(out_count1), out_ovf1, 1, expQ1[0]);
          if (out_ready) void'(expQ1.pop_front());
        end
      end
      if (in_valid && in_ready0 && in_ready1) modelAccept(in_a, in_b, in_last);
    end
  end

  always @(posedge clock) begin
    if (randReady) begin
      #1 out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Holds the term until an edge with in_ready seen high; returns just after that edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit last);
    bit ok = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      ok = in_ready0 && in_ready1;
      @(posedge clock);
      #1;
      done = ok;
    end
    if (!done) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL accept timeout: got in_ready low for 200 cycles, expected acceptance");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
  endtask

  task automatic waitResult();
    bit got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clock);
      got = out_valid0;
    end
    if (!got) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL result timeout: got out_valid low for 30 cycles, expected a result");
    end
  endtask

  initial begin
    vecs[0] = '{32'd3, 32'd5, 128'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'd1, 128'hFFFFFFFF};
    vecs[2] = '{32'd0, 32'hDEADBEEF, 128'd0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 128'hFFFFFFFE_00000001};
    vecs[4] = '{32'h00010000, 32'h00010000, 128'h1_00000000};
    vecs[5] = '{32'h80000000, 32'h80000000, 128'h40000000_00000000};
    vecs[6] = '{32'd1234, 32'd5678, 128'd7006652};

    // Reset held with a live input: nothing may come out of it.
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9; in_last = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkVal("reset out_valid", 128'({out_valid0, out_valid1}), 128'd0);
    checkVal("reset out_acc", 128'(out_acc0) | 128'(out_acc1), 128'd0);
    checkVal("reset out_count", 128'({out_count0, out_count1}), 128'd0);
    checkVal("reset out_ovf", 128'({out_ovf0, out_ovf1}), 128'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    idle();
    @(negedge clock);
    checkVal("in_ready after reset", 128'({in_ready0, in_ready1}), 128'd3);
    repeat (4) @(negedge clock);
    checkVal("no result from reset input", 128'({out_valid0, out_valid1}), 128'd0);
    @(posedge clock); #1;

    // Single term latency: visible only after the second edge past accept.
    applyStimulus(32'd3, 32'd5, 1'b1);
    idle();
    @(negedge clock);
    checkVal("latency edge0 valid", 128'(out_valid0), 128'd0);
    @(negedge clock);
    checkVal("latency edge1 valid", 128'(out_valid0), 128'd0);
    @(negedge clock);
    checkVal("latency edge2 valid", 128'({out_valid0, out_valid1}), 128'd3);
    checkVal("single acc", 128'(out_acc0), 128'd15);
    checkVal("single count", 128'(out_count0), 128'd1);
    checkVal("single ovf", 128'(out_ovf0), 128'd0);
    @(negedge clock);
    checkVal("single one cycle", 128'(out_valid0), 128'd0);
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1);
      idle();
      waitResult();
      checkVal($sformatf("vec%0d acc72", i), 128'(out_acc0), vecs[i].expProd);
      checkVal($sformatf("vec%0d acc64", i), 128'(out_acc1), vecs[i].expProd);
      checkVal($sformatf("vec%0d count", i), 128'(out_count0), 128'd1);
      @(posedge clock); #1;
    end

    // Back-to-back groups; the 64-bit instance wraps on the 4-term group.
    for (int i = 0; i < 4; i++) applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, i == 3);
    applyStimulus(32'd2, 32'd7, 1'b1);
    idle();
    waitResult();
    checkVal("b2b acc72", 128'(out_acc0), 128'h3_FFFFFFF8_00000004);
    checkVal("b2b count72", 128'(out_count0), 128'd4);
    checkVal("b2b ovf72", 128'(out_ovf0), 128'd0);
    checkVal("b2b acc64", 128'(out_acc1), 128'hFFFFFFF8_00000004);
    checkVal("b2b ovf64", 128'(out_ovf1), 128'd1);
    @(negedge clock);
    checkVal("b2b second valid", 128'(out_valid0), 128'd1);
    checkVal("b2b second acc", 128'(out_acc0), 128'd14);
    checkVal("b2b second count", 128'(out_count0), 128'd1);
    @(posedge clock); #1;

    // Overflow then a clean single term: overflow must not leak across groups.
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    applyStimulus(32'd1, 32'd1, 1'b1);
    idle();
    waitResult();
    checkVal("ovf acc64", 128'(out_acc1), 128'hFFFFFFFC_00000002);
    checkVal("ovf flag64", 128'(out_ovf1), 128'd1);
    checkVal("ovf acc72", 128'(out_acc0), 128'h1_FFFFFFFC_00000002);
    checkVal("ovf flag72", 128'(out_ovf0), 128'd0);
    @(negedge clock);
    checkVal("post-ovf acc64", 128'(out_acc1), 128'd1);
    checkVal("post-ovf flag64", 128'(out_ovf1), 128'd0);
    @(posedge clock); #1;

    // 20 terms saturate the 4-bit counter but not the sum.
    for (int i = 0; i < 20; i++) applyStimulus(32'd1, 32'd1, i == 19);
    idle();
    waitResult();
    checkVal("sat count4", 128'(out_count1), 128'd15);
    checkVal("sat acc64", 128'(out_acc1), 128'd20);
    checkVal("sat count16", 128'(out_count0), 128'd20);
    @(posedge clock); #1;

    // Backpressure: three single-term groups while the output is blocked.
    out_ready = 1'b0;
    applyStimulus(32'd1, 32'd1, 1'b1);
    applyStimulus(32'd2, 32'd2, 1'b1);
    applyStimulus(32'd3, 32'd3, 1'b1);
    idle();
    repeat (3) @(negedge clock);
    checkVal("bp in_ready low", 128'(in_ready0), 128'd0);
    checkVal("bp held acc", 128'(out_acc0), 128'd1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    checkVal("bp drain 1", 128'(out_acc0), 128'd1);
    @(negedge clock);
    checkVal("bp drain 4", 128'(out_acc0), 128'd4);
    @(negedge clock);
    checkVal("bp drain 9", 128'(out_acc0), 128'd9);
    @(negedge clock);
    checkVal("bp drained", 128'(out_valid0), 128'd0);
    @(posedge clock); #1;

    // Reset mid-group discards the partial sum.
    applyStimulus(32'd5, 32'd5, 1'b0);
    applyStimulus(32'd5, 32'd5, 1'b0);
    idle();
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    applyStimulus(32'd2, 32'd7, 1'b1);
    idle();
    waitResult();
    checkVal("midreset acc", 128'(out_acc0), 128'd14);
    checkVal("midreset count", 128'(out_count0), 128'd1);
    checkVal("midreset ovf", 128'(out_ovf0), 128'd0);
    @(posedge clock); #1;

    // Random groups with random gaps and random backpressure.
    randReady = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clock); #1;
      end
      applyStimulus(($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                    ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                    $urandom_range(0, 3) == 0);
    end
    applyStimulus($urandom, $urandom, 1'b1);
    idle();
    randReady = 0;
    @(posedge clock);
    #2 out_ready = 1'b1;
    repeat (20) @(negedge clock);
    checkVal("all results drained72", 128'(expQ0.size()), 128'd0);
    checkVal("all results drained64", 128'(expQ1.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
